// File: rtl/usb4_tx_pkg.sv
// Shared transmit-side definitions: data-bus select codes and the training state encoding.
package usb4_tx_pkg;

    localparam logic [3:0] DSEL_SLOS1  = 4'd0;
    localparam logic [3:0] DSEL_SLOS2  = 4'd1;
    localparam logic [3:0] DSEL_G3_TS1 = 4'd2;
    localparam logic [3:0] DSEL_G3_TS2 = 4'd3;
    localparam logic [3:0] DSEL_G4_TS1 = 4'd4;
    localparam logic [3:0] DSEL_G4_TS2 = 4'd5;
    localparam logic [3:0] DSEL_G4_TS3 = 4'd6;
    localparam logic [3:0] DSEL_G4_TS4 = 4'd7;
    localparam logic [3:0] DSEL_DATA   = 4'd8;
    localparam logic [3:0] DSEL_IDLE   = 4'd9;

    typedef enum logic [3:0] {
        S_SLOS1  = 4'd0,
        S_SLOS2  = 4'd1,
        S_G3_TS1 = 4'd2,
        S_G3_TS2 = 4'd3,
        S_G4_TS1 = 4'd4,
        S_G4_TS2 = 4'd5,
        S_G4_TS3 = 4'd6,
        S_G4_TS4 = 4'd7,
        S_DATA   = 4'd8,
        S_IDLE   = 4'd9,
        S_ERR    = 4'd10
    } state_t;

    // ERR drives the bus quiet, same as IDLE
    function automatic logic [3:0] dsel_of(input state_t s);
        logic [3:0] d;
        case (s)
            S_SLOS1:  d = DSEL_SLOS1;
            S_SLOS2:  d = DSEL_SLOS2;
            S_G3_TS1: d = DSEL_G3_TS1;
            S_G3_TS2: d = DSEL_G3_TS2;
            S_G4_TS1: d = DSEL_G4_TS1;
            S_G4_TS2: d = DSEL_G4_TS2;
            S_G4_TS3: d = DSEL_G4_TS3;
            S_G4_TS4: d = DSEL_G4_TS4;
            S_DATA:   d = DSEL_DATA;
            default:  d = DSEL_IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tx_os_watchdog.sv
// Stall watchdog: counts cycles while running, cleared on demand, flags when the limit is reached.
module tx_os_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int TMO_W   = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, then saturating increment while running
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TMO_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/tx_os_sequencer.sv
// Ordered-set training sequencer: walks the Gen3 or Gen4 phase chain, counting bus completions
// and gating each advance on the partner-match handshake, then holds the link in DATA.
module tx_os_sequencer
    import usb4_tx_pkg::*;
#(
    parameter int SLOS_REPS  = 2,
    parameter int G3_TS_REPS = 32,
    parameter int G4_TS_REPS = 16,
    parameter int TS4_REPS   = 16,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 4096,
    parameter int TMO_W      = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       gen4_i,
    input  logic       abort_i,
    input  logic       os_sent_i,
    input  logic       rx_os_match_i,
    output logic [3:0] d_sel_o,
    output logic [3:0] cur_state_o,
    output logic       phase_done_o,
    output logic       link_up_o,
    output logic       error_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
    logic             rx_seen_q, rx_seen_d;
    logic [3:0]       d_sel_q;
    logic             phase_done_q, link_up_q, error_q;

    logic [CNT_W-1:0] reps_m1_s;
    logic             needs_rx_s, training_s;
    state_t           next_phase_s;
    logic             adv_cond_s, advance_s, state_chg_s;
    logic             wdog_clr_s, wdog_exp_s;

    // Phase table: per-state repeat target, handshake need and successor
    always_comb begin
        reps_m1_s    = '0;
        needs_rx_s   = 1'b0;
        training_s   = 1'b1;
        next_phase_s = S_IDLE;
        case (state_q)
            S_SLOS1:  begin reps_m1_s = CNT_W'(SLOS_REPS - 1);  next_phase_s = S_SLOS2;  end
            S_SLOS2:  begin reps_m1_s = CNT_W'(SLOS_REPS - 1);  next_phase_s = S_G3_TS1; end
            S_G3_TS1: begin reps_m1_s = CNT_W'(G3_TS_REPS - 1); needs_rx_s = 1'b1; next_phase_s = S_G3_TS2; end
            S_G3_TS2: begin reps_m1_s = CNT_W'(G3_TS_REPS - 1); needs_rx_s = 1'b1; next_phase_s = S_DATA;   end
            S_G4_TS1: begin reps_m1_s = CNT_W'(G4_TS_REPS - 1); needs_rx_s = 1'b1; next_phase_s = S_G4_TS2; end
            S_G4_TS2: begin reps_m1_s = CNT_W'(G4_TS_REPS - 1); needs_rx_s = 1'b1; next_phase_s = S_G4_TS3; end
            S_G4_TS3: begin reps_m1_s = CNT_W'(G4_TS_REPS - 1); needs_rx_s = 1'b1; next_phase_s = S_G4_TS4; end
            S_G4_TS4: begin reps_m1_s = CNT_W'(TS4_REPS - 1);   next_phase_s = S_DATA;   end
            default:  begin training_s = 1'b0; end
        endcase
    end

    assign adv_cond_s = training_s && os_sent_i && (os_cnt_q == reps_m1_s) &&
                        (rx_seen_q || rx_os_match_i || !needs_rx_s);

    // Next state: exits beat advance; a completion in the expiry cycle proves the bus is alive
    always_comb begin
        state_d   = state_q;
        advance_s = 1'b0;
        if (state_q == S_IDLE) begin
            if (start_i && !abort_i) begin
                state_d = gen4_i ? S_G4_TS1 : S_SLOS1;
            end else begin
                state_d = S_IDLE;
            end
        end else if (!start_i || abort_i) begin
            state_d = S_IDLE;
        end else if (adv_cond_s) begin
            advance_s = 1'b1;
            state_d   = next_phase_s;
        end else if (wdog_exp_s && !os_sent_i) begin
            state_d = S_ERR;
        end else begin
            state_d = state_q;
        end
    end

    assign state_chg_s = (state_d != state_q);

    // Per-phase completion count and sticky partner match, both restarted on any state change
    always_comb begin
        os_cnt_d  = os_cnt_q;
        rx_seen_d = rx_seen_q;
        if (state_chg_s) begin
            os_cnt_d  = '0;
            rx_seen_d = 1'b0;
        end else begin
            rx_seen_d = rx_seen_q || rx_os_match_i;
            if (os_sent_i && (os_cnt_q < reps_m1_s)) begin
                os_cnt_d = os_cnt_q + CNT_W'(1);
            end else begin
                os_cnt_d = os_cnt_q;
            end
        end
    end

    assign wdog_clr_s = os_sent_i || state_chg_s || !training_s;

    tx_os_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (wdog_clr_s),
        .run_i     (training_s),
        .expired_o (wdog_exp_s)
    );

    // State, counters and Moore outputs, all loaded from the next state so they move together
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            os_cnt_q     <= '0;
            rx_seen_q    <= 1'b0;
            d_sel_q      <= DSEL_IDLE;
            phase_done_q <= 1'b0;
            link_up_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            rx_seen_q    <= rx_seen_d;
            d_sel_q      <= dsel_of(state_d);
            phase_done_q <= advance_s;
            link_up_q    <= (state_d == S_DATA);
            error_q      <= (state_d == S_ERR);
        end
    end

    assign d_sel_o      = d_sel_q;
    assign cur_state_o  = state_q;
    assign phase_done_o = phase_done_q;
    assign link_up_o    = link_up_q;
    assign error_o      = error_q;

endmodule
